// File: rtl/ace_video_pkg.sv
// rtl/ace_video_pkg.sv - shared Jupiter Ace video timing constants
package ace_video_pkg;

  // Input (native) timing of the Ace video generator
  localparam int HTOTAL_IN   = 416;
  localparam int VTOTAL_IN   = 312;
  localparam int HACTIVE     = 256;
  localparam int VACTIVE     = 192;
  localparam int HS_IN_START = 308;
  localparam int HS_IN_END   = 340;

  // Scandoubler output defaults
  localparam int SD_OHS_START = 308;
  localparam int SD_OHS_LEN   = 16;
  localparam int SD_LBW       = 9;

endpackage

// File: rtl/ace_linebuf.sv
// rtl/ace_linebuf.sv - two-bank 1-bit line buffer, one write port, one registered read port
module ace_linebuf
  import ace_video_pkg::*;
#(
  parameter int AW = SD_LBW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  // Address MSB selects the bank; the lower bits are the pixel index.
  logic mem [0:(1<<AW)-1];
  logic rdata_q;
  logic rdata_d;

  // Write port: storage cells are not reset, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data updates only on enabled reads so it holds across idle clocks
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  // Registered read output
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ace_scandoubler.sv
// rtl/ace_scandoubler.sv - line-doubling scan converter for the Jupiter Ace video stream
module ace_scandoubler
  import ace_video_pkg::*;
#(
  parameter int HTOTAL    = HTOTAL_IN,
  parameter int HACTIVE   = ace_video_pkg::HACTIVE,
  parameter int OHS_START = SD_OHS_START,
  parameter int OHS_LEN   = SD_OHS_LEN,
  parameter int LBW       = SD_LBW
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_pix,
  input  logic ce_2x,
  input  logic vid_in,
  input  logic hs_in,
  input  logic vs_in,
  input  logic vb_in,
  output logic vid_out,
  output logic hs_out,
  output logic vs_out,
  output logic hb_out,
  output logic vb_out
);

  localparam logic [LBW-1:0] CNT_MAX   = '1;
  localparam logic [LBW-1:0] CNT_ONE   = LBW'(1);
  localparam logic [LBW-1:0] OCNT_LAST = LBW'(HTOTAL - 1);
  localparam logic [LBW-1:0] HACT_C    = LBW'(HACTIVE);
  localparam logic [LBW-1:0] OHS_LO    = LBW'(OHS_START);
  localparam logic [LBW-1:0] OHS_HI    = LBW'(OHS_START + OHS_LEN);

  logic [LBW-1:0] wcnt_q, wcnt_d;
  logic [LBW-1:0] ocnt_q, ocnt_d;
  logic           wbank_q, wbank_d;
  logic           hs_prev_q, hs_prev_d;
  logic           vs_line_q, vs_line_d;
  logic           vb_line_q, vb_line_d;
  logic           hs_q, hs_d;
  logic           hb_q, hb_d;

  logic           line_start;
  logic           wr_bank;
  logic [LBW-1:0] wr_addr;
  logic           rd_data;

  // A line begins on the hsync falling edge as seen at the input pixel rate.
  assign line_start = ce_pix & hs_prev_q & ~hs_in;

  // The pixel that carries the edge already belongs to the new line: it goes
  // to address 0 of the freshly selected bank, so the counter moves on to 1.
  assign wr_bank = line_start ? ~wbank_q : wbank_q;
  assign wr_addr = line_start ? '0 : wcnt_q;

  // Next state for the write/read counters, bank select, sync latches and outputs
  always_comb begin
    wcnt_d    = wcnt_q;
    ocnt_d    = ocnt_q;
    wbank_d   = wbank_q;
    hs_prev_d = hs_prev_q;
    vs_line_d = vs_line_q;
    vb_line_d = vb_line_q;
    hs_d      = hs_q;
    hb_d      = hb_q;

    if (ce_pix) begin
      hs_prev_d = hs_in;
      wcnt_d    = (wcnt_q == CNT_MAX) ? CNT_MAX : wcnt_q + CNT_ONE;
    end

    if (ce_2x) begin
      ocnt_d = (ocnt_q == OCNT_LAST) ? '0 : ocnt_q + CNT_ONE;
      hs_d   = ~((ocnt_q >= OHS_LO) && (ocnt_q < OHS_HI));
      hb_d   = (ocnt_q >= HACT_C);
    end

    if (line_start) begin
      wbank_d   = ~wbank_q;
      wcnt_d    = CNT_ONE;
      ocnt_d    = '0;
      hs_d      = 1'b1;
      vs_line_d = vs_in;
      vb_line_d = vb_in;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q    <= '0;
      ocnt_q    <= '0;
      wbank_q   <= 1'b0;
      hs_prev_q <= 1'b1;
      vs_line_q <= 1'b1;
      vb_line_q <= 1'b1;
      hs_q      <= 1'b1;
      hb_q      <= 1'b1;
    end else begin
      wcnt_q    <= wcnt_d;
      ocnt_q    <= ocnt_d;
      wbank_q   <= wbank_d;
      hs_prev_q <= hs_prev_d;
      vs_line_q <= vs_line_d;
      vb_line_q <= vb_line_d;
      hs_q      <= hs_d;
      hb_q      <= hb_d;
    end
  end

  ace_linebuf #(
    .AW(LBW + 1)
  ) u_linebuf (
    .clk   (clk),
    .reset (reset),
    .we    (ce_pix),
    .waddr ({wr_bank, wr_addr}),
    .wdata (vid_in),
    .re    (ce_2x),
    .raddr ({~wbank_q, ocnt_q}),
    .rdata (rd_data)
  );

  assign vid_out = rd_data & ~hb_q & ~vb_line_q;
  assign hs_out  = hs_q;
  assign hb_out  = hb_q;
  assign vs_out  = vs_line_q;
  assign vb_out  = vb_line_q;

endmodule

// File: tb/tb_ace_scandoubler.sv
// tb/tb_ace_scandoubler.sv - scoreboard bench for ace_scandoubler
module tb_ace_scandoubler;

  typedef struct packed {
    logic vid;
    logic hs;
    logic hb;
    logic vs;
    logic vb;
  } exp_t;

  logic clk = 1'b0;
  logic reset, ce_pix, ce_2x, vid_in, hs_in, vs_in, vb_in;
  logic vid_out, hs_out, vs_out, hb_out, vb_out;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t mon_got, mon_exp;
  logic ce2x_seen = 1'b0;
  bit   check_en  = 1'b0;
  logic model_mem [0:1][0:511];
  logic m_wbank;
  int   last_o;
  int   line_no;

  always #5 clk = ~clk;

  ace_scandoubler dut (
    .clk     (clk),
    .reset   (reset),
    .ce_pix  (ce_pix),
    .ce_2x   (ce_2x),
    .vid_in  (vid_in),
    .hs_in   (hs_in),
    .vs_in   (vs_in),
    .vb_in   (vb_in),
    .vid_out (vid_out),
    .hs_out  (hs_out),
    .vs_out  (vs_out),
    .hb_out  (hb_out),
    .vb_out  (vb_out)
  );

  // Remember whether the last active edge was an output pixel edge
  always @(posedge clk) ce2x_seen <= ce_2x;

  // Monitor: every output pixel pops one expected entry
  always @(negedge clk) begin
    if (check_en && ce2x_seen) begin
      mon_got = {vid_out, hs_out, hb_out, vs_out, vb_out};
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got vid/hs/hb/vs/vb=%b with no expected entry", mon_got);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_out line %0d: got vid/hs/hb/vs/vb=%b expected %b",
                   line_no, mon_got, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input logic cp, input logic c2);
    ce_pix = cp;
    ce_2x  = c2;
    @(posedge clk);
    #1;
  endtask

  function automatic logic pix(input int pat, input int p);
    case (pat)
      0:       return 1'b0;
      1:       return logic'(p % 2 == 0);
      2:       return logic'(p % 3 == 0);
      3:       return logic'((p / 8) % 2 == 1);
      default: return logic'((p * 7) % 5 < 2);
    endcase
  endfunction

  // Expected output when the read counter held o and the read bank was rb
  function automatic exp_t mk_exp(input int o, input logic rb, input logic force_hs,
                                  input logic vs, input logic vb);
    exp_t e;
    logic hb;
    hb    = (o >= 256);
    e.vid = model_mem[rb][o] & ~hb & ~vb;
    e.hs  = force_hs ? 1'b1 : !((o >= 308) && (o < 324));
    e.hb  = hb;
    e.vs  = vs;
    e.vb  = vb;
    return e;
  endfunction

  // One input line: pixel 0 carries the hsync falling edge, hsync low for 32 pixels
  task automatic send_line(input int len, input int pat, input logic vs, input logic vb);
    logic px;
    int   o;
    for (int p = 0; p < len; p++) begin
      px     = pix(pat, p);
      vid_in = px;
      hs_in  = (p < 32) ? 1'b0 : 1'b1;
      vs_in  = vs;
      vb_in  = vb;
      if (p == 0) begin
        sb_q.push_back(mk_exp(last_o, ~m_wbank, 1'b1, vs, vb));
        m_wbank = ~m_wbank;
      end else begin
        o = (2 * p - 1) % 416;
        sb_q.push_back(mk_exp(o, ~m_wbank, 1'b0, vs, vb));
      end
      model_mem[m_wbank][(p > 511) ? 511 : p] = px;
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b0);
      o = (2 * p) % 416;
      sb_q.push_back(mk_exp(o, ~m_wbank, 1'b0, vs, vb));
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
    end
    last_o = (2 * len - 1) % 416;
    line_no++;
  endtask

  initial begin
    logic [9:0] idx;
    reset  = 1'b1;
    ce_pix = 1'b0;
    ce_2x  = 1'b0;
    vid_in = 1'b0;
    hs_in  = 1'b1;
    vs_in  = 1'b1;
    vb_in  = 1'b1;
    line_no = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++)
        model_mem[b][a] = 1'b0;
    @(posedge clk);
    #1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    reset = 1'b0;

    // Unchecked free-running traffic so the reset below lands mid-stream
    for (int p = 0; p < 150; p++) begin
      vid_in = logic'(p % 3 == 1);
      hs_in  = (p % 50 < 10) ? 1'b0 : 1'b1;
      vs_in  = logic'(p % 7 != 0);
      vb_in  = 1'b0;
      tick(1'b1, 1'b1);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
    end

    reset = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    reset  = 1'b0;
    ce_pix = 1'b0;
    ce_2x  = 1'b0;
    @(negedge clk);
    check("rst_hs_out", int'(hs_out), 1);
    check("rst_vs_out", int'(vs_out), 1);
    check("rst_hb_out", int'(hb_out), 1);
    check("rst_vb_out", int'(vb_out), 1);
    check("rst_vid_out", int'(vid_out), 0);
    check("rst_ocnt", int'(dut.ocnt_q), 0);
    check("rst_wcnt", int'(dut.wcnt_q), 0);
    check("rst_wbank", int'(dut.wbank_q), 0);
    m_wbank = 1'b0;
    last_o  = 0;
    #1;
    check_en = 1'b1;

    send_line(416, 0, 1'b1, 1'b1);
    send_line(416, 1, 1'b1, 1'b1);
    send_line(416, 2, 1'b1, 1'b0);
    send_line(416, 3, 1'b0, 1'b0);
    send_line(416, 4, 1'b0, 1'b0);
    send_line(300, 1, 1'b1, 1'b0);
    check("short_wbank", int'(dut.wbank_q), int'(m_wbank));
    send_line(416, 2, 1'b1, 1'b0);
    send_line(600, 3, 1'b1, 1'b0);
    check("long_wcnt_sat", int'(dut.wcnt_q), 511);
    idx = {m_wbank, 9'h1FF};
    check("long_last_cell", int'(dut.u_linebuf.mem[idx]), int'(pix(3, 599)));
    send_line(416, 4, 1'b1, 1'b0);
    send_line(416, 1, 1'b1, 1'b0);
    send_line(416, 0, 1'b1, 1'b0);

    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
